// File: rtl/piso_sequencer.sv
// piso_sequencer: drains an n x m result buffer row-major into a valid/ready stream.
// Define PISO_SEQ_LAST_EN to add the out_last end-of-matrix marker.
module piso_sequencer #(
    parameter int M      = 256,
    parameter int N      = 256,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        n_dim,
    input  logic [7:0]        m_dim,
    output logic              send,
    output logic [7:0]        selO_n,
    output logic [7:0]        selO_m,
    input  logic [DATA_W-1:0] result_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PISO_SEQ_LAST_EN
    output logic              out_last,
`endif
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH, DONE} state_t;

    state_t            state_q;
    logic [7:0]        n_q, m_q, row_q, col_q;
    logic              infl_q;
    logic [1:0]        cnt_q, cnt_d;
    logic              wr_q, rd_q;
    logic [DATA_W-1:0] fifo_q [2];
    logic              busy_q, done_q, err_q;
    logic              dims_ok, pop, push, last_rd;

    assign dims_ok = (n_dim != 8'd0) && (m_dim != 8'd0)
                  && (int'({24'd0, n_dim}) <= N)
                  && (int'({24'd0, m_dim}) <= M);

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = fifo_q[rd_q];
    assign pop       = out_valid && out_ready;
    assign push      = infl_q;
    assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    assign last_rd   = (row_q == n_q - 8'd1) && (col_q == m_q - 8'd1);

    // In-flight read reserves a slot; a same-cycle pop frees one.
    assign send = (state_q == SEND)
               && (((cnt_q + {1'b0, infl_q}) < 2'd2) || pop);

    assign selO_n = row_q;
    assign selO_m = col_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

`ifdef PISO_SEQ_LAST_EN
    logic [1:0] last_q;
    logic       infl_last_q;

    assign out_last = out_valid && last_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= 2'b00;
            infl_last_q <= 1'b0;
        end else begin
            infl_last_q <= send && last_rd;
            if (push) last_q[wr_q] <= infl_last_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= 8'd0;
            m_q       <= 8'd0;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            infl_q    <= 1'b0;
            cnt_q     <= 2'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            infl_q <= send;
            cnt_q  <= cnt_d;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (push) begin
                fifo_q[wr_q] <= result_data;
                wr_q         <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            unique case (state_q)
                IDLE: begin
                    if (start && dims_ok) begin
                        n_q     <= n_dim;
                        m_q     <= m_dim;
                        row_q   <= 8'd0;
                        col_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (send) begin
                        if (last_rd) begin
                            row_q   <= 8'd0;
                            col_q   <= 8'd0;
                            state_q <= FLUSH;
                        end else if (col_q == m_q - 8'd1) begin
                            col_q <= 8'd0;
                            row_q <= row_q + 8'd1;
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_d == 2'd0 && !infl_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_sequencer.sv
// tb_piso_sequencer: random and directed drains checked against a
// row-major sequence model with a simple latency/occupancy scoreboard.
module tb_piso_sequencer;

    localparam int M  = 16;
    localparam int N  = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    n_dim = 8'd0;
    logic [7:0]    m_dim = 8'd0;
    logic          send;
    logic [7:0]    selO_n, selO_m;
    logic [DW-1:0] result_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          busy, done, err;
`ifdef PISO_SEQ_LAST_EN
    logic          out_last;
    int            last_hits;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rmode = 0;
    logic [15:0] salt = 16'h0;

    bit   active = 1'b0;
    bit   done_seen = 1'b0;
    int   mm = 1, total = 0;
    int   send_cnt = 0, pop_cnt = 0;
    int   start_cyc = 0, last_pop_cyc = -10;
    int   first_valid_cyc = -1, done_cyc = -1;
    logic [DW-1:0] first_data, last_data, prev_data;
    bit   prev_stall = 1'b0;

    piso_sequencer #(.M(M), .N(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .n_dim(n_dim), .m_dim(m_dim), .send(send),
        .selO_n(selO_n), .selO_m(selO_m),
        .result_data(result_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
`ifdef PISO_SEQ_LAST_EN
        .out_last(out_last),
`endif
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word(input int r, input int c);
        return {salt, 8'(r), 8'(c)};
    endfunction

    // Result buffer: one-cycle read latency.
    always @(posedge clk)
        result_data <= send ? word(int'(selO_n), int'(selO_m)) : 32'hBAD0BAD0;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("done", 64'(done), 64'(active && pop_cnt == total && cyc == last_pop_cyc + 1));
            chk("busy", 64'(busy), 64'(active && cyc >= start_cyc));
            if (!busy) chk("sel_idle", {selO_n, selO_m}, 64'd0);
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && active && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                chk("first_valid_lat", 64'(cyc - start_cyc), 64'd2);
            end
`ifdef PISO_SEQ_LAST_EN
            chk("out_last", 64'(out_last), 64'(out_valid && active && pop_cnt == total - 1));
            if (out_valid && out_ready && out_last) last_hits++;
`endif
            if (send) begin
                if (active && send_cnt < total) begin
                    chk("sel", {selO_n, selO_m}, {8'(send_cnt / mm), 8'(send_cnt % mm)});
                    send_cnt++;
                end else begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL send_unexpected: got send=1 expected 0 (cycle %0d)", cyc);
                end
            end
            if (out_valid && out_ready) begin
                if (active && pop_cnt < total) begin
                    chk("data", 64'(out_data), 64'(word(pop_cnt / mm, pop_cnt % mm)));
                    if (pop_cnt == 0) first_data = out_data;
                    last_data = out_data;
                    pop_cnt++;
                    if (pop_cnt == total) last_pop_cyc = cyc;
                end else begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pop_extra: got pop expected none (cycle %0d)", cyc);
                end
            end
            if (send) chk("outstanding_le2", 64'(send_cnt - pop_cnt <= 2), 64'd1);
            if (done && active) begin
                done_cyc = cyc;
                done_seen = 1'b1;
                active = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic begin_drain(input int n, input int m, input int mode);
        @(posedge clk);
        #1;
        rmode = mode;
        salt = 16'($urandom);
        mm = m;
        total = n * m;
        send_cnt = 0;
        pop_cnt = 0;
        last_pop_cyc = -10;
        first_valid_cyc = -1;
        done_cyc = -1;
        start_cyc = 1 << 30;
        done_seen = 1'b0;
        active = 1'b1;
        n_dim = 8'(n);
        m_dim = 8'(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
    endtask

    task automatic run_drain(input int n, input int m, input int mode, input bit hold);
        begin_drain(n, m, mode);
        if (!hold) start = 1'b0;
        for (int i = 0; i < 3000 && !done_seen; i++) @(posedge clk);
        #1;
        start = 1'b0;
        if (!done_seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: no done for %0dx%0d", n, m);
            active = 1'b0;
        end
        chk("pop_total", 64'(pop_cnt), 64'(total));
        chk("send_total", 64'(send_cnt), 64'(total));
        if (mode == 0 && done_seen)
            chk("no_bubbles", 64'(done_cyc - start_cyc), 64'(total + 2));
    endtask

    task automatic try_bad(input int n, input int m);
        @(posedge clk);
        #1;
        n_dim = 8'(n);
        m_dim = 8'(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_pulse", 64'(err), 64'd1);
        chk("err_busy", 64'(busy), 64'd0);
        chk("err_send", 64'(send), 64'd0);
        @(posedge clk);
        #1;
        chk("err_clear", 64'(err), 64'd0);
        chk("err_busy2", 64'(busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_send"}, 64'(send), 64'd0);
        chk({nm, "_sel"}, {selO_n, selO_m}, 64'd0);
        chk({nm, "_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_data"}, 64'(out_data), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
        chk({nm, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
`ifdef PISO_SEQ_LAST_EN
        last_hits = 0;
`endif
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_drain(2, 3, 0, 1'b0);
        chk("w00_literal", 64'(first_data), {32'd0, salt, 16'h0000});
        chk("w12_literal", 64'(last_data), {32'd0, salt, 16'h0102});
        chk("last_pop_at", 64'(last_pop_cyc - start_cyc), 64'd7);
        chk("done_at", 64'(done_cyc - start_cyc), 64'd8);

        try_bad(0, 3);
        try_bad(3, M + 1);
        try_bad(N + 1, 2);
        try_bad(2, 0);

        run_drain(4, 4, 1, 1'b0);
        run_drain(1, 1, 0, 1'b0);
        chk("w1x1_literal", 64'(last_data), {32'd0, salt, 16'h0000});

        begin_drain(8, 8, 0);
        start = 1'b0;
        for (int i = 0; i < 200 && pop_cnt < 5; i++) @(posedge clk);
        #1;
        chk("pops_before_rst", 64'(pop_cnt), 64'd5);
        rst = 1'b1;
        active = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_drain(1, 1, 0, 1'b0);

        run_drain(3, 3, 0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("held_start_idle", 64'(busy), 64'd0);

`ifdef PISO_SEQ_LAST_EN
        last_hits = 0;
        run_drain(2, 2, 2, 1'b0);
        chk("last_pulses", 64'(last_hits), 64'd1);
`endif

        for (int k = 0; k < 8; k++)
            run_drain($urandom_range(1, 5), $urandom_range(1, 5),
                      $urandom_range(0, 2), 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
